lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store initiator that sits between the CPU datapath and the word-organised data memory. It accepts one load or store request at a time and checks alignment. Sub-word stores are turned into a read-modify-write sequence. The block drives the memory's word port (combinational read, write on clock edge) and returns a sign/zero-extended result with a one-cycle completion pulse.

## Interface
Parameters:
- none (32-bit address/data fixed by the ISA)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_op  in  3  operation code (LW, LH, LHU, LB, LBU, SW, SH, SB), from lsu_pkg
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- req_pc  in  32  PC of issuing instruction, forwarded for write tracing
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_err  out  1  misaligned access, valid with resp_valid
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wd  out  32  write word
- mem_rd  in  32  combinational read word at mem_addr
- mem_pc  out  32  latched req_pc, drives memory's trace input

## Operation
- Little-endian lanes. Byte lane = addr[1:0], bits [8*lane+7 : 8*lane]. Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Misaligned: LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]=1. Never touches memory.
- Handshake: request accepted on an edge with req_valid && req_ready. Op, address, wdata and pc are latched in that cycle. Inputs are ignored while req_ready=0.
- FSM states (enum in lsu_pkg): IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP.
  - IDLE: on accept, misaligned → RESP with err flag set. Loads → LOAD. SW → WRITE. SH/SB → RMW_RD. No accept → stay in IDLE.
  - LOAD: mem_addr = {addr[31:2],2'b00}. Extract lane from mem_rd, extend (LB/LH sign, LBU/LHU zero), register into resp_rdata. → RESP.
  - WRITE: mem_we=1, mem_wd=wdata. → RESP.
  - RMW_RD: drive mem_addr, mem_we=0. Register mem_rd into merge buffer. → RMW_WR.
  - RMW_WR: mem_we=1. mem_wd = merge buffer with the target lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH). → RESP.
  - RESP: resp_valid=1. resp_err = err flag. resp_rdata = load result, else 0. → IDLE.
- mem_we is asserted only in WRITE and RMW_WR, for exactly one cycle per store.
- mem_addr and mem_wd are 0 in IDLE and RESP.
- mem_pc = latched pc from accept until the next accept.

## Timing
- Accept edge = cycle 0. resp_valid is high in cycle:
  - error: 1
  - LW/LH/LHU/LB/LBU/SW: 2
  - SH/SB: 3
- req_ready rises again the cycle after RESP. Back-to-back throughput is one request per 3 (loads, SW) or 4 (SH/SB) cycles.
- Reset values: state=IDLE, req_ready=1 (from the cycle after reset), resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wd=0, mem_pc=0.
- Reset mid-operation wins over every transition. In particular, reset asserted in RMW_RD or RMW_WR suppresses the merged write: mem_we is forced 0 in any cycle where reset=1. No response is issued for the aborted request.
- A request with req_valid in the same cycle as reset is dropped.

## Structure
- lsu_pkg holds:
  - op encodings: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7
  - state enum
  - helper constants BYTE_W=8, HALF_W=16
- One natural combinational sub-module, lsu_lane, with two functions:
  - extract: mem_rd, addr[1:0], op → extended load value
  - merge: old word, wdata, addr[1:0], op → merged write word
- lsu_ctrl itself holds the FSM, input latches, merge buffer and output registers.

## Test plan
- Memory word at 0x10 = 0x1122_3344. LB 0x13 → resp_rdata 0x0000_0011 at cycle 2. LB 0x12 with word 0x1180_3344 → 0xFFFF_FF80. LBU same → 0x0000_0080.
- Word 0x10 = 0x1122_3344. SB addr 0x11, wdata 0xDEAD_BEAA:
  - cycle 1: mem_we=0
  - cycle 2: mem_we=1, mem_addr=0x10, mem_wd=0x1122_AA44
  - cycle 3: resp_valid=1, resp_rdata=0
- SH addr 0x12, wdata 0x0000_BEEF over 0x1122_3344 → mem_wd 0xBEEF_3344. LH 0x12 then → 0xFFFF_BEEF. LHU → 0x0000_BEEF.
- SW addr 0x16 and LH addr 0x13:
  - resp_valid at cycle 1 with resp_err=1
  - mem_we never asserted, memory unchanged
- SB issued, reset asserted in RMW_RD cycle:
  - no mem_we pulse, no resp_valid
  - memory word unchanged
  - the cycle after reset deasserts, req_ready=1 and all outputs are at reset values
- Back-to-back LW 0x20 then SW 0x24 with req_valid held:
  - second accept occurs on the cycle after the first RESP
  - req_ready=0 in between
  - exactly one mem_we pulse, at the second request's cycle 1

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
// Holds the operation encodings, the controller state encodings, lane
// widths and the alignment rule used to reject bad accesses.
package lsu_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    // Operation encodings as issued by the CPU datapath
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    // Controller states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_WRITE  = 3'd2;
    localparam logic [2:0] ST_RMW_RD = 3'd3;
    localparam logic [2:0] ST_RMW_WR = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    // Word accesses need addr[1:0]==0, half accesses need addr[0]==0
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
        logic bad;
        case (op)
            OP_LW, OP_SW:          bad = (lane != 2'b00);
            OP_LH, OP_LHU, OP_SH:  bad = lane[0];
            default:               bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: bundle of the CPU request/response handshake and the memory
// word port seen by the load/store unit.
//   master : CPU + memory environment (drives requests and mem_rd)
//   slave  : the load/store controller
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [31:0] mem_pc;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_pc, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_addr, mem_wd, mem_pc
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_pc, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_addr, mem_wd, mem_pc
    );
endinterface

// File: rtl/lsu_lane.sv
// lsu_lane: combinational little-endian lane logic.
//   op, lane    : operation and byte offset within the word
//   rd_word     : word read from memory (load path)
//   old_word    : word captured for read-modify-write
//   wdata       : low half of store data (SB uses [7:0], SH uses [15:0])
//   load_data   : extracted and sign/zero-extended load result
//   merge_data  : old_word with the addressed lane replaced by store data
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] old_word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    function automatic logic [31:0] extract(input logic [31:0] rd, input logic [1:0] ln,
                                            input logic [2:0] opc);
        logic [BYTE_W-1:0] b;
        logic [HALF_W-1:0] h;
        logic [31:0]       r;
        case (ln)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            2'd3:    b = rd[31:24];
            default: b = rd[7:0];
        endcase
        h = ln[1] ? rd[31:16] : rd[15:0];
        case (opc)
            OP_LW:   r = rd;
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h00_0000, b};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [15:0] wd,
                                          input logic [1:0] ln, input logic [2:0] opc);
        logic [31:0] r;
        r = old;
        case (opc)
            OP_SB: begin
                case (ln)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    2'd3:    r[31:24] = wd[7:0];
                    default: r = old;
                endcase
            end
            OP_SH: begin
                if (ln[1]) begin
                    r[31:16] = wd;
                end else begin
                    r[15:0] = wd;
                end
            end
            default: r = old;
        endcase
        return r;
    endfunction

    assign load_data  = extract(rd_word, lane, op);
    assign merge_data = merge(old_word, wdata, lane, op);

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store initiator.
//   clk, reset : clock and synchronous active-high reset
//   bus        : lsu_if.slave -- request/response handshake plus the
//                memory word port (combinational read, write on clk edge)
// Sub-word stores are done as read-modify-write; misaligned accesses
// answer with resp_err one cycle after accept without touching memory.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    lsu_if.slave  bus
);

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [2:0]  op_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] pc_r;
    logic [31:0] merge_buf_r;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] resp_rdata_r;
    logic        ready_s;
    logic        accept_s;
    logic        misaligned_s;
    logic [31:0] load_data_s;
    logic [31:0] merge_data_s;
    logic        mem_we_s;
    logic [31:0] mem_addr_s;
    logic [31:0] mem_wd_s;

    // A request arriving together with reset is dropped
    assign ready_s      = (state_r == ST_IDLE) && !reset;
    assign accept_s     = bus.req_valid && ready_s;
    assign misaligned_s = is_misaligned(bus.req_op, bus.req_addr[1:0]);

    lsu_lane u_lane (
        .op         (op_r),
        .lane       (addr_r[1:0]),
        .rd_word    (bus.mem_rd),
        .old_word   (merge_buf_r),
        .wdata      (wdata_r[15:0]),
        .load_data  (load_data_s),
        .merge_data (merge_data_s)
    );

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (misaligned_s) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        case (bus.req_op)
                            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: state_nxt_s = ST_LOAD;
                            OP_SW:                               state_nxt_s = ST_WRITE;
                            OP_SH, OP_SB:                        state_nxt_s = ST_RMW_RD;
                            default:                             state_nxt_s = ST_RESP;
                        endcase
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD:   state_nxt_s = ST_RESP;
            ST_WRITE:  state_nxt_s = ST_RESP;
            ST_RMW_RD: state_nxt_s = ST_RMW_WR;
            ST_RMW_WR: state_nxt_s = ST_RESP;
            ST_RESP:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Memory port drive; idle and response cycles present all zeros
    always_comb begin
        mem_we_s   = 1'b0;
        mem_addr_s = 32'h0000_0000;
        mem_wd_s   = 32'h0000_0000;
        case (state_r)
            ST_LOAD, ST_RMW_RD: begin
                mem_addr_s = {addr_r[31:2], 2'b00};
            end
            ST_WRITE: begin
                mem_we_s   = 1'b1;
                mem_addr_s = {addr_r[31:2], 2'b00};
                mem_wd_s   = wdata_r;
            end
            ST_RMW_WR: begin
                mem_we_s   = 1'b1;
                mem_addr_s = {addr_r[31:2], 2'b00};
                mem_wd_s   = merge_data_s;
            end
            default: begin
                mem_we_s   = 1'b0;
                mem_addr_s = 32'h0000_0000;
                mem_wd_s   = 32'h0000_0000;
            end
        endcase
    end

    // State, request latches, merge buffer and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            op_r         <= 3'd0;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            pc_r         <= 32'h0000_0000;
            merge_buf_r  <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                op_r    <= bus.req_op;
                addr_r  <= bus.req_addr;
                wdata_r <= bus.req_wdata;
                pc_r    <= bus.req_pc;
            end
            if (state_r == ST_RMW_RD) begin
                merge_buf_r <= bus.mem_rd;
            end
            resp_valid_r <= (state_nxt_s == ST_RESP);
            // Only the accept path can reach RESP with an alignment error
            resp_err_r   <= accept_s && misaligned_s;
            // Result lives only in the RESP cycle; stores and errors return 0
            resp_rdata_r <= (state_r == ST_LOAD) ? load_data_s : 32'h0000_0000;
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_rdata = resp_rdata_r;
    // Reset must never let a half-finished store reach memory
    assign bus.mem_we     = mem_we_s && !reset;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wd     = mem_wd_s;
    assign bus.mem_pc     = pc_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl with a word memory model,
// a directed vector table, multi-cycle corner sequences and random traffic
// checked against an arithmetic reference model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    lsu_if bus();

    lsu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Word memory: combinational read, write on rising edge, preload path
    logic [31:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;
    int          we_total = 0;
    logic [31:0] shadow [0:63];

    assign bus.mem_rd = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wd;
        if (bus.mem_we) we_total <= we_total + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = addr[7:2];
        pl_val = val;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    // Reference: access size, lane shift and masks in plain arithmetic
    function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] old,
                                  output logic err, output logic [31:0] rdata,
                                  output int lat, output logic [31:0] new_word);
        int size;
        longint lane, val, mask;
        bit store, sgn;
        case (op)
            OP_LW, OP_SW:         size = 4;
            OP_LH, OP_LHU, OP_SH: size = 2;
            default:              size = 1;
        endcase
        store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
        sgn   = (op == OP_LH) || (op == OP_LB);
        lane  = longint'(addr % 4);
        err   = (addr % size) != 0;
        mask  = (longint'(1) << (8 * size)) - 1;
        new_word = old;
        rdata    = 32'h0;
        if (err) begin
            lat = 1;
        end else if (!store) begin
            val = (longint'(old) >> (8 * lane)) & mask;
            if (sgn && val > (mask >> 1)) val = val - (mask + 1);
            rdata = val[31:0];
            lat = 2;
        end else begin
            new_word = 32'((longint'(old) & ~(mask << (8 * lane)))
                           | ((longint'(wdata) & mask) << (8 * lane)));
            lat = (size == 4) ? 2 : 3;
        end
    endfunction

    // Issue one request from a negedge and observe cycles 1..6
    task automatic run_txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] pc,
                           input logic exp_err, input logic [31:0] exp_rdata,
                           input int exp_lat, input logic [31:0] exp_word);
        int resp_cyc = 0, resp_cnt = 0, we_cnt = 0, we_cyc = 0;
        logic [31:0] got_rdata = 32'h0, got_wd = 32'h0, got_wa = 32'h0;
        logic got_err = 1'b0;
        logic exp_we;
        exp_we = !exp_err && ((op == OP_SW) || (op == OP_SH) || (op == OP_SB));
        chk({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_pc    = pc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (bus.resp_valid) begin
                resp_cnt++;
                if (resp_cyc == 0) begin
                    resp_cyc  = c;
                    got_rdata = bus.resp_rdata;
                    got_err   = bus.resp_err;
                end
            end
            if (bus.mem_we) begin
                we_cnt++;
                we_cyc = c;
                got_wd = bus.mem_wd;
                got_wa = bus.mem_addr;
            end
            if (c < 6) @(negedge clk);
        end
        chk({tag, " resp_cycle"}, resp_cyc, exp_lat);
        chk({tag, " resp_count"}, resp_cnt, 32'd1);
        chk({tag, " resp_err"}, {31'd0, got_err}, {31'd0, exp_err});
        chk({tag, " resp_rdata"}, got_rdata, exp_rdata);
        chk({tag, " we_count"}, we_cnt, {31'd0, exp_we});
        if (exp_we) begin
            chk({tag, " we_cycle"}, we_cyc, exp_lat - 1);
            chk({tag, " mem_wd"}, got_wd, exp_word);
            chk({tag, " mem_addr"}, got_wa, {addr[31:2], 2'b00});
        end
        chk({tag, " mem_word"}, mem[addr[7:2]], exp_word);
        chk({tag, " mem_pc"}, bus.mem_pc, pc);
    endtask

    // Abort a SB with reset at cycle 'at' (1 = RMW_RD, 2 = RMW_WR)
    task automatic reset_abort(input int at);
        int we0, rv_cnt;
        preload(32'h30, 32'h1122_3344);
        we0 = we_total;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SB;
        bus.req_addr  = 32'h31;
        bus.req_wdata = 32'h0000_0077;
        bus.req_pc    = 32'h200;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (at == 2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort mem_we_in_reset", {31'd0, bus.mem_we}, 32'd0);
        chk("abort resp_valid_in_reset", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("abort mem_addr", bus.mem_addr, 32'h0);
        chk("abort mem_wd", bus.mem_wd, 32'h0);
        chk("abort mem_pc", bus.mem_pc, 32'h0);
        chk("abort resp_rdata", bus.resp_rdata, 32'h0);
        chk("abort resp_err", {31'd0, bus.resp_err}, 32'd0);
        rv_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid) rv_cnt++;
        end
        chk("abort no_resp", rv_cnt, 32'd0);
        chk("abort no_write", we_total - we0, 32'd0);
        chk("abort mem_word", mem[12], 32'h1122_3344);
    endtask

    // LW then SW with req_valid held throughout
    task automatic back_to_back();
        logic [7:0] rdy_b = 8'h0, rv_b = 8'h0, we_b = 8'h0;
        logic [31:0] rd2 = 32'h0;
        int we0;
        preload(32'h20, 32'h0BAD_F00D);
        preload(32'h24, 32'h0000_0000);
        we0 = we_total;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_LW;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hFFFF_FFFF;
        bus.req_pc    = 32'h100;
        @(negedge clk);
        bus.req_op    = OP_SW;
        bus.req_addr  = 32'h24;
        bus.req_wdata = 32'h5A5A_1234;
        bus.req_pc    = 32'h104;
        for (int c = 1; c <= 7; c++) begin
            rdy_b[c] = bus.req_ready;
            rv_b[c]  = bus.resp_valid;
            we_b[c]  = bus.mem_we;
            if (c == 2) rd2 = bus.resp_rdata;
            if (c == 4) bus.req_valid = 1'b0;
            if (c < 7) @(negedge clk);
        end
        chk("b2b ready_pattern", {24'd0, rdy_b}, 32'h0000_00C8);
        chk("b2b resp_pattern", {24'd0, rv_b}, 32'h0000_0024);
        chk("b2b we_pattern", {24'd0, we_b}, 32'h0000_0010);
        chk("b2b we_total", we_total - we0, 32'd1);
        chk("b2b lw_rdata", rd2, 32'h0BAD_F00D);
        chk("b2b sw_mem", mem[9], 32'h5A5A_1234);
        chk("b2b mem_pc", bus.mem_pc, 32'h104);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] word;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_addr, r_wd, r_pc, r_rd, r_new;
        logic        r_err;
        int          r_lat;

        tbl[0]  = '{OP_LB,  32'h13, 32'h0,         32'h1122_3344, 1'b0, 32'h0000_0011, 2, 32'h1122_3344};
        tbl[1]  = '{OP_LB,  32'h12, 32'h0,         32'h1180_3344, 1'b0, 32'hFFFF_FF80, 2, 32'h1180_3344};
        tbl[2]  = '{OP_LBU, 32'h12, 32'h0,         32'h1180_3344, 1'b0, 32'h0000_0080, 2, 32'h1180_3344};
        tbl[3]  = '{OP_SB,  32'h11, 32'hDEAD_BEAA, 32'h1122_3344, 1'b0, 32'h0,         3, 32'h1122_AA44};
        tbl[4]  = '{OP_SH,  32'h12, 32'h0000_BEEF, 32'h1122_3344, 1'b0, 32'h0,         3, 32'hBEEF_3344};
        tbl[5]  = '{OP_LH,  32'h12, 32'h0,         32'hBEEF_3344, 1'b0, 32'hFFFF_BEEF, 2, 32'hBEEF_3344};
        tbl[6]  = '{OP_LHU, 32'h12, 32'h0,         32'hBEEF_3344, 1'b0, 32'h0000_BEEF, 2, 32'hBEEF_3344};
        tbl[7]  = '{OP_SW,  32'h16, 32'h1234_5678, 32'hA5A5_A5A5, 1'b1, 32'h0,         1, 32'hA5A5_A5A5};
        tbl[8]  = '{OP_LH,  32'h13, 32'h0,         32'h1122_3344, 1'b1, 32'h0,         1, 32'h1122_3344};
        tbl[9]  = '{OP_LW,  32'h10, 32'h0,         32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D};
        tbl[10] = '{OP_SW,  32'h14, 32'h8765_4321, 32'h0000_0000, 1'b0, 32'h0,         2, 32'h8765_4321};
        tbl[11] = '{OP_LB,  32'h10, 32'h0,         32'h1122_3344, 1'b0, 32'h0000_0044, 2, 32'h1122_3344};
        tbl[12] = '{OP_SB,  32'h13, 32'h0000_00F0, 32'h1122_3344, 1'b0, 32'h0,         3, 32'hF022_3344};
        tbl[13] = '{OP_LHU, 32'h10, 32'h0,         32'h1122_8344, 1'b0, 32'h0000_8344, 2, 32'h1122_8344};

        pl_en         = 1'b0;
        pl_idx        = 6'd0;
        pl_val        = 32'h0;
        reset         = 1'b1;
        // A store presented during reset must be dropped
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SW;
        bus.req_addr  = 32'h40;
        bus.req_wdata = 32'hFFFF_FFFF;
        bus.req_pc    = 32'h0000_0ABC;
        repeat (3) @(negedge clk);
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("reset resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("reset resp_rdata", bus.resp_rdata, 32'h0);
        chk("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("reset mem_addr", bus.mem_addr, 32'h0);
        chk("reset mem_wd", bus.mem_wd, 32'h0);
        chk("reset mem_pc", bus.mem_pc, 32'h0);
        repeat (3) @(negedge clk);
        chk("reset dropped_req", we_total, 32'd0);

        for (int i = 0; i < 14; i++) begin
            preload(tbl[i].addr, tbl[i].pre);
            run_txn($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wdata,
                    32'h1000 + 32'(i * 4), tbl[i].err, tbl[i].rdata, tbl[i].lat, tbl[i].word);
        end

        reset_abort(1);
        reset_abort(2);
        back_to_back();

        for (int i = 0; i < 64; i++) begin
            shadow[i] = $urandom;
            preload({24'd0, i[5:0], 2'b00}, shadow[i]);
        end
        for (int i = 0; i < 40; i++) begin
            r_op   = 3'($urandom_range(0, 7));
            r_addr = 32'($urandom_range(0, 255));
            r_wd   = $urandom;
            r_pc   = $urandom;
            model(r_op, r_addr, r_wd, shadow[r_addr[7:2]], r_err, r_rd, r_lat, r_new);
            run_txn($sformatf("rnd%0d op%0d @%h", i, r_op, r_addr), r_op, r_addr, r_wd, r_pc,
                    r_err, r_rd, r_lat, r_new);
            shadow[r_addr[7:2]] = r_new;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
